// File: rtl/tile_writer.sv
// tile_writer: write-side engine for the 15x20 level tile map.
//
// Converts pixel-coordinate tile-write requests into row/column writes on the
// tile memory write port through a small in-order request queue.
// Out-of-bounds requests are accepted but dropped and counted.
//
// Optional feature macro: TILE_WRITER_FILL_EN
//   defined     - fill_start/fill_tile sweep-fill the whole map, one write
//                 per cycle in row-major order. Queued requests wait and
//                 drain after the sweep.
//   not defined - fill logic absent; fill_start and fill_tile are ignored.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   req_valid/ready  request handshake; req_x/req_y pixel coords, req_tile code
//   fill_start       single-cycle pulse starting a full-map fill of fill_tile
//   busy             fill in progress or queue non-empty
//   wr_en/row/col/   registered tile memory write port; values hold when
//   wr_data          wr_en is low
//   drop_cnt         saturating count of out-of-bounds requests
module tile_writer #(
    parameter int unsigned ROW_MAX    = 14,
    parameter int unsigned COL_MAX    = 19,
    parameter int unsigned LEFT       = 144,
    parameter int unsigned TOP        = 35,
    parameter int unsigned TILE_W     = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [9:0]        req_x,
    input  logic [9:0]        req_y,
    input  logic [TILE_W-1:0] req_tile,
    input  logic              fill_start,
    input  logic [TILE_W-1:0] fill_tile,
    output logic              busy,
    output logic              wr_en,
    output logic [5:0]        wr_row,
    output logic [5:0]        wr_col,
    output logic [TILE_W-1:0] wr_data,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // Request conversion and bounds check
    // ------------------------------------------------------------------
    logic [9:0] dy, dx, row_full, col_full;
    logic       in_bounds, accept, push, pop;

    assign dy       = req_y - 10'(TOP);
    assign dx       = req_x - 10'(LEFT);
    assign row_full = dy >> 5;
    assign col_full = dx >> 5;

    // Underflow is tested on the raw coordinates; a wrapped difference could
    // otherwise shift down to a small, seemingly valid index.
    assign in_bounds = (req_y >= 10'(TOP)) && (req_x >= 10'(LEFT)) &&
                       (row_full <= 10'(ROW_MAX)) && (col_full <= 10'(COL_MAX));

    assign accept = req_valid && req_ready;
    assign push   = accept && in_bounds;

    // ------------------------------------------------------------------
    // Request FIFO {row, col, tile}
    // ------------------------------------------------------------------
    logic [5:0]        row_mem  [FIFO_DEPTH];
    logic [5:0]        col_mem  [FIFO_DEPTH];
    logic [TILE_W-1:0] tile_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              fifo_empty, fifo_full;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            row_mem[wr_ptr_q]  <= row_full[5:0];
            col_mem[wr_ptr_q]  <= col_full[5:0];
            tile_mem[wr_ptr_q] <= req_tile;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Drop counter (saturating)
    // ------------------------------------------------------------------
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (accept && !in_bounds && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;

    // ------------------------------------------------------------------
    // Write sequencing
    // ------------------------------------------------------------------
    logic              wr_en_q, wr_en_d;
    logic [5:0]        wr_row_q, wr_row_d, wr_col_q, wr_col_d;
    logic [TILE_W-1:0] wr_data_q, wr_data_d;

`ifdef TILE_WRITER_FILL_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    // Position written right after (0,0), and whether (0,0) is the whole map.
    localparam logic       SINGLE_TILE = (ROW_MAX == 0) && (COL_MAX == 0);
    localparam logic [5:0] SECOND_ROW  = (COL_MAX == 0) ? 6'd1 : 6'd0;
    localparam logic [5:0] SECOND_COL  = (COL_MAX == 0) ? 6'd0 : 6'd1;

    logic [0:0]        state_q, state_d;
    logic [5:0]        fill_row_q, fill_row_d, fill_col_q, fill_col_d;
    logic [TILE_W-1:0] fill_tile_q, fill_tile_d;
    logic              fill_last;

    assign fill_last = (fill_row_q == 6'(ROW_MAX)) && (fill_col_q == 6'(COL_MAX));

    always_comb begin
        state_d     = state_q;
        fill_row_d  = fill_row_q;
        fill_col_d  = fill_col_q;
        fill_tile_d = fill_tile_q;
        pop         = 1'b0;
        wr_en_d     = 1'b0;
        wr_row_d    = wr_row_q;
        wr_col_d    = wr_col_q;
        wr_data_d   = wr_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fill_start) begin
                    // First fill write goes out on the same edge that samples
                    // fill_start; the counters point at the second tile.
                    wr_en_d     = 1'b1;
                    wr_row_d    = 6'd0;
                    wr_col_d    = 6'd0;
                    wr_data_d   = fill_tile;
                    fill_tile_d = fill_tile;
                    fill_row_d  = SECOND_ROW;
                    fill_col_d  = SECOND_COL;
                    if (!SINGLE_TILE) state_d = ST_FILL;
                end else if (!fifo_empty) begin
                    pop       = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_row_d  = row_mem[rd_ptr_q];
                    wr_col_d  = col_mem[rd_ptr_q];
                    wr_data_d = tile_mem[rd_ptr_q];
                end
            end
            ST_FILL: begin
                wr_en_d   = 1'b1;
                wr_row_d  = fill_row_q;
                wr_col_d  = fill_col_q;
                wr_data_d = fill_tile_q;
                if (fill_last) begin
                    state_d = ST_IDLE;
                end else if (fill_col_q == 6'(COL_MAX)) begin
                    fill_col_d = 6'd0;
                    fill_row_d = fill_row_q + 6'd1;
                end else begin
                    fill_col_d = fill_col_q + 6'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fill_row_q  <= '0;
            fill_col_q  <= '0;
            fill_tile_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_row_q  <= fill_row_d;
            fill_col_q  <= fill_col_d;
            fill_tile_q <= fill_tile_d;
        end
    end

    assign req_ready = !fifo_full && (state_q != ST_FILL);
    assign busy      = (state_q == ST_FILL) || !fifo_empty;
`else
    logic unused_fill;
    assign unused_fill = ^{fill_start, fill_tile};

    always_comb begin
        pop       = !fifo_empty;
        wr_en_d   = pop;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        wr_data_d = wr_data_q;
        if (pop) begin
            wr_row_d  = row_mem[rd_ptr_q];
            wr_col_d  = col_mem[rd_ptr_q];
            wr_data_d = tile_mem[rd_ptr_q];
        end
    end

    assign req_ready = !fifo_full;
    assign busy      = !fifo_empty;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_row  = wr_row_q;
    assign wr_col  = wr_col_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_tile_writer.sv
// tb_tile_writer: self-checking bench for tile_writer.
// A transaction-level model (queue of pending writes, fill progress as a tile
// index) predicts every write-port value, req_ready, busy and drop_cnt each
// cycle. Define TILE_WRITER_FILL_EN for both RTL and bench to cover fills.
module tb_tile_writer;

    localparam int NROW  = 15;
    localparam int NCOL  = 20;
    localparam int NTILE = NROW * NCOL;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [9:0] req_x = '0;
    logic [9:0] req_y = '0;
    logic [2:0] req_tile = '0;
    logic       fill_start = 1'b0;
    logic [2:0] fill_tile = '0;
    logic       busy;
    logic       wr_en;
    logic [5:0] wr_row, wr_col;
    logic [2:0] wr_data;
    logic [7:0] drop_cnt;

    tile_writer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_tile   (req_tile),
        .fill_start (fill_start),
        .fill_tile  (fill_tile),
        .busy       (busy),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int row;
        int col;
        int tile;
    } wr_t;

    wr_t m_q[$];
    int  m_fill_left = 0;  // fill writes still to be issued
    int  m_fill_tile = 0;
    int  m_drop      = 0;
    int  e_en = 0, e_row = 0, e_col = 0, e_data = 0;

    function automatic int m_ready();
        return ((m_q.size() < 4) && (m_fill_left == 0)) ? 1 : 0;
    endfunction

    function automatic int m_busy();
        return ((m_fill_left > 0) || (m_q.size() > 0)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_fill_left = 0;
        m_fill_tile = 0;
        m_drop      = 0;
        e_en = 0; e_row = 0; e_col = 0; e_data = 0;
    endtask

    task automatic model_step();
        int  rdy, x, y, idx;
        wr_t w;
        rdy  = m_ready();
        e_en = 0;
        if (m_fill_left > 0) begin
            idx    = NTILE - m_fill_left;
            e_en   = 1;
            e_row  = idx / NCOL;
            e_col  = idx % NCOL;
            e_data = m_fill_tile;
            m_fill_left--;
        end
`ifdef TILE_WRITER_FILL_EN
        else if (fill_start) begin
            m_fill_tile = int'(fill_tile);
            e_en   = 1;
            e_row  = 0;
            e_col  = 0;
            e_data = m_fill_tile;
            m_fill_left = NTILE - 1;
        end
`endif
        else if (m_q.size() > 0) begin
            w      = m_q.pop_front();
            e_en   = 1;
            e_row  = w.row;
            e_col  = w.col;
            e_data = w.tile;
        end
        if (req_valid && (rdy != 0)) begin
            x = int'(req_x);
            y = int'(req_y);
            if (y >= 35 && x >= 144 && (y - 35) / 32 < NROW && (x - 144) / 32 < NCOL) begin
                w.row  = (y - 35) / 32;
                w.col  = (x - 144) / 32;
                w.tile = int'(req_tile);
                m_q.push_back(w);
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle output comparison, away from the active edge
    // ------------------------------------------------------------------
    int n_wr = 0;
    int last_row = -1, last_col = -1;

    initial begin
        forever begin
            @(negedge clk);
            check("wr_en",     wr_en,     e_en);
            check("wr_row",    wr_row,    e_row);
            check("wr_col",    wr_col,    e_col);
            check("wr_data",   wr_data,   e_data);
            check("req_ready", req_ready, m_ready());
            check("busy",      busy,      m_busy());
            check("drop_cnt",  drop_cnt,  m_drop);
            if (wr_en) begin
                n_wr++;
                last_row = int'(wr_row);
                last_col = int'(wr_col);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge)
    // ------------------------------------------------------------------
    // Presents a request and returns at the falling edge after it is taken.
    // req_valid stays high; the caller overwrites or clears it.
    task automatic send(input int x, input int y, input int tile);
        int t;
        t = 0;
        req_valid = 1'b1;
        req_x     = 10'(x);
        req_y     = 10'(y);
        req_tile  = 3'(tile);
        while (!req_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("send_accept", req_ready, 1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_rand_valid();
        send($urandom_range(144, 783), $urandom_range(35, 514), $urandom_range(0, 7));
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_wr_en",  wr_en,     0);
        check("rst_busy",   busy,      0);
        check("rst_ready",  req_ready, 1);
        check("rst_drop",   drop_cnt,  0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(tag, busy, 0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int base, t, op;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_wr_en",   wr_en,     0);
        check("reset_wr_row",  wr_row,    0);
        check("reset_wr_col",  wr_col,    0);
        check("reset_wr_data", wr_data,   0);
        check("reset_ready",   req_ready, 1);
        check("reset_busy",    busy,      0);
        check("reset_drop",    drop_cnt,  0);
        rst = 1'b0;
        idle(2);

        // Single write: accepted at E0, strobe in the cycle after E0+1.
        send(245, 99, 5);
        req_valid = 1'b0;
        @(negedge clk);
        check("single_en",   wr_en,   1);
        check("single_row",  wr_row,  2);
        check("single_col",  wr_col,  3);
        check("single_data", wr_data, 5);
        idle(3);
        check("single_drop", drop_cnt, 0);

        // Bounds
        send(100, 99, 2);
        send(784, 99, 2);
        send(200, 515, 2);
        send(783, 514, 1);
        idle(4);
        check("bounds_drop", drop_cnt, 3);
        check("bounds_row",  last_row, 14);
        check("bounds_col",  last_col, 19);

        // Back-to-back
        base = n_wr;
        repeat (4) send_rand_valid();
        idle(6);
        check("b2b_writes", n_wr - base, 4);

`ifdef TILE_WRITER_FILL_EN
        // Fill with pending writes
        fill_tile  = 3'd0;
        fill_start = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        base = n_wr;
        repeat (5) send_rand_valid();
        idle(1);
        wait_idle("fill_drain");
        check("fill_writes", n_wr - base, NTILE + 5);

        // Reset mid-fill
        fill_tile  = 3'd6;
        fill_start = 1'b1;
        @(negedge clk);
        fill_start = 1'b0;
        base = n_wr;
        t = 0;
        while (n_wr < base + 100 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("fill_progress", (n_wr >= base + 100), 1);
        pulse_reset();
`else
        // Reset with writes pending
        send_rand_valid();
        send_rand_valid();
        send_rand_valid();
        req_valid = 1'b0;
        pulse_reset();
`endif
        base = n_wr;
        send(245, 99, 3);
        idle(3);
        check("post_reset_writes", n_wr - base, 1);
        check("post_reset_row", last_row, 2);
        check("post_reset_col", last_col, 3);

        // Saturation
        base = n_wr;
        repeat (260) send(100, 99, 1);
        idle(3);
        check("sat_drop",   drop_cnt,    255);
        check("sat_writes", n_wr - base, 0);
        pulse_reset();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 49);
            if (op < 30) begin
                send_rand_valid();
            end else if (op < 40) begin
                send($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 7));
            end else if (op == 40) begin
                fill_tile  = 3'($urandom_range(0, 7));
                fill_start = 1'b1;
                @(negedge clk);
                fill_start = 1'b0;
            end else begin
                idle($urandom_range(1, 3));
            end
        end
        idle(1);
        wait_idle("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
